smc777_ioctl_loader: RTL and testbench
======================================

Name: smc777_ioctl_loader

Overview:
Receiving end of the HPS ioctl download stream: consumes the byte stream produced by hps_io and commits each byte to on-chip memory through a req/ack port. Index 0 (BIOS .rom) is written to the IPL ROM array. Index 1 (.bin) is parsed for a 4-byte header, and its payload is written to main RAM. The CPU is held in reset for the whole transfer, and hps_io is throttled through ioctl_wait whenever the memory port is slower than the stream.

Parameters:
ROM_AW, 14, IPL ROM address width (16 KiB); ROM bytes at or above 2^ROM_AW are discarded.
RAM_AW, 16, main RAM address width; payload addresses wrap modulo 2^RAM_AW.

Ports:
clk  in  1  system clock (clk_sys)
reset  in  1  asynchronous, active-high reset
ioctl_download  in  1  high for the duration of a transfer
ioctl_index  in  8  file slot: 0 = BIOS, 1 = BIN, others ignored
ioctl_wr  in  1  one-cycle byte strobe
ioctl_addr  in  25  byte offset within the file
ioctl_dout  in  8  byte data
ioctl_wait  out  1  stall request to hps_io
mem_req  out  1  write request to ROM/RAM arbiter
mem_sel  out  1  0 = ROM, 1 = RAM
mem_addr  out  16  byte address (ROM uses [ROM_AW-1:0])
mem_data  out  8  write byte
mem_ack  in  1  arbiter accepted the current request
cpu_hold  out  1  holds the CPU in reset
load_done  out  1  one-cycle pulse at end of transfer
exec_addr  out  16  BIN entry point
exec_valid  out  1  exec_addr is valid
byte_count  out  25  bytes committed in the last or current transfer
err_size  out  1  sticky until next transfer start: ROM overflow or short BIN
err_overrun  out  1  sticky until next transfer start: strobe received while the buffer was full

Behaviour:
- Reset (asynchronous): all outputs 0; state IDLE; buffer empty; load_addr = 0. A reset during a transfer drops mem_req immediately and produces no load_done.
- States: IDLE, ACTIVE, DRAIN, DONE.
- IDLE -> ACTIVE on rising ioctl_download with index 0 or 1:
  - latch index;
  - clear byte_count, err_size, err_overrun, exec_valid;
  - cpu_hold = 1 from the next cycle.
- Other index values: stay IDLE, ignore all strobes, never assert ioctl_wait.
- One-entry buffer: on ioctl_wr in ACTIVE, capture {addr, data}.
  - A strobe that arrives while the buffer is full is dropped and sets err_overrun.
- ioctl_wait = registered (buf_valid | mem_req). It is high from the cycle after a captured strobe until the cycle after mem_ack.
- Byte routing, index 0:
  - if ioctl_addr < 2^ROM_AW: issue a write with mem_sel = 0, mem_addr = ioctl_addr[ROM_AW-1:0] zero-extended;
  - otherwise drop the byte and set err_size.
- Byte routing, index 1:
  - offsets 0/1: load_addr low/high byte;
  - offsets 2/3: exec_addr low/high byte;
  - header bytes are consumed internally and generate no mem_req;
  - offset N >= 4: mem_sel = 1, mem_addr = (load_addr + N - 4) mod 2^RAM_AW, truncated to RAM_AW bits.
- Memory handshake:
  - mem_req rises the cycle after the buffer fills;
  - mem_addr, mem_sel and mem_data stay stable while mem_req is high;
  - mem_ack is sampled only while mem_req is high; on ack, mem_req falls next cycle, buffer empties, byte_count++;
  - the next mem_req can rise no earlier than the cycle after that;
  - mem_ack while mem_req is low is ignored.
- ACTIVE -> DRAIN on falling ioctl_download. DRAIN waits until the buffer is empty and mem_req is low.
- DRAIN -> DONE: load_done = 1 for one cycle.
  - exec_valid = 1 if index 1 and all 4 header bytes were received;
  - if index 1 and fewer than 4 bytes were received, set err_size and keep exec_valid = 0.
- DONE -> IDLE next cycle; cpu_hold falls the same cycle. exec_addr and exec_valid hold until the next transfer starts.
- A strobe coincident with the falling ioctl_download is still accepted.

Test Plan:
- BIOS load with immediate ack:
  - stimulus: index 0, bytes 0x00..0xFF at offsets 0..255, mem_ack tied 1;
  - required: 256 writes with mem_sel = 0 and mem_addr = offset; byte_count = 256; one load_done pulse; cpu_hold high throughout and low after DONE; err flags 0.
- Slow arbiter:
  - stimulus: mem_ack asserted 5 cycles after each mem_req;
  - required: ioctl_wait high during each stall; mem_addr/mem_data stable across the stall; no err_overrun; byte order preserved.
- BIN header and wrap:
  - stimulus: index 1, header 0xFE 0xFF 0x00 0x80, payload 0xAA 0xBB 0xCC;
  - required: writes to RAM 0xFFFE = 0xAA, 0xFFFF = 0xBB, 0x0000 = 0xCC; exec_addr = 0x8000; exec_valid = 1; byte_count = 3.
- Boundaries:
  - ROM overflow: index 0 byte at offset 0x4000 -> no mem_req, err_size = 1.
  - Short BIN: index 1 with only 2 bytes -> no writes, err_size = 1, exec_valid = 0.
  - Overrun: second strobe while the buffer is full -> second byte dropped, err_overrun = 1.
- Reset mid-transfer:
  - stimulus: assert reset while mem_req is high;
  - required: mem_req, cpu_hold and ioctl_wait are 0 asynchronously; no load_done; a following index 0 transfer completes normally.
- Ignored index:
  - stimulus: index 2 download with 10 strobes;
  - required: no mem_req, ioctl_wait = 0, cpu_hold = 0, load_done never pulses.

Source files
------------

// File: rtl/smc777_ioctl_loader.sv
// smc777_ioctl_loader: commits the hps_io download stream to IPL ROM (index 0) or main RAM (index 1, 4-byte header)
// through a one-entry buffer and a req/ack memory port, holding the CPU in reset while loading.
module smc777_ioctl_loader #(
    parameter int ROM_AW = 14,
    parameter int RAM_AW = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        mem_req,
    output logic        mem_sel,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    input  logic        mem_ack,
    output logic        cpu_hold,
    output logic        load_done,
    output logic [15:0] exec_addr,
    output logic        exec_valid,
    output logic [24:0] byte_count,
    output logic        err_size,
    output logic        err_overrun
);
    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

    localparam logic [15:0] ROM_MASK = 16'((32'd1 << ROM_AW) - 32'd1);
    localparam logic [15:0] RAM_MASK = 16'((32'd1 << RAM_AW) - 32'd1);

    state_t      state_q, state_d;
    logic        dl_q, bin_q, bin_d;
    logic        buf_valid_q, buf_valid_d;
    logic [24:0] buf_addr_q, buf_addr_d;
    logic [7:0]  buf_data_q, buf_data_d;
    logic        mem_req_q, mem_req_d, mem_sel_q, mem_sel_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_data_q, mem_data_d;
    logic [15:0] load_addr_q, load_addr_d, exec_addr_q, exec_addr_d;
    logic [3:0]  hdr_q, hdr_d;
    logic        exec_valid_q, exec_valid_d, cpu_hold_q, cpu_hold_d;
    logic        load_done_q, load_done_d, wait_q, wait_d;
    logic [24:0] byte_count_q, byte_count_d;
    logic        err_size_q, err_size_d, err_overrun_q, err_overrun_d;
    logic        rom_ok, hdr_byte;
    logic [15:0] ram_addr;

    assign rom_ok   = (buf_addr_q >> ROM_AW) == 25'd0;
    assign hdr_byte = buf_addr_q < 25'd4;
    // Payload offset N lands at load_addr + N - 4, wrapped to the RAM size.
    assign ram_addr = (load_addr_q + buf_addr_q[15:0] - 16'd4) & RAM_MASK;

    always_comb begin
        state_d       = state_q;
        bin_d         = bin_q;
        buf_valid_d   = buf_valid_q;
        buf_addr_d    = buf_addr_q;
        buf_data_d    = buf_data_q;
        mem_req_d     = mem_req_q;
        mem_sel_d     = mem_sel_q;
        mem_addr_d    = mem_addr_q;
        mem_data_d    = mem_data_q;
        load_addr_d   = load_addr_q;
        exec_addr_d   = exec_addr_q;
        hdr_d         = hdr_q;
        exec_valid_d  = exec_valid_q;
        cpu_hold_d    = cpu_hold_q;
        load_done_d   = 1'b0;
        byte_count_d  = byte_count_q;
        err_size_d    = err_size_q;
        err_overrun_d = err_overrun_q;
        unique case (state_q)
            IDLE: if (ioctl_download && !dl_q && ioctl_index[7:1] == 7'd0) begin
                state_d       = ACTIVE;
                bin_d         = ioctl_index[0];
                byte_count_d  = '0;
                err_size_d    = 1'b0;
                err_overrun_d = 1'b0;
                exec_valid_d  = 1'b0;
                hdr_d         = '0;
                cpu_hold_d    = 1'b1;
            end
            ACTIVE: if (!ioctl_download) state_d = DRAIN;
            DRAIN: if (!buf_valid_q && !mem_req_q) begin
                state_d      = DONE;
                load_done_d  = 1'b1;
                exec_valid_d = bin_q && (&hdr_q);
                err_size_d   = err_size_q | (bin_q && !(&hdr_q));
            end
            DONE: begin
                state_d    = IDLE;
                cpu_hold_d = 1'b0;
            end
        endcase
        // The falling-download cycle is still ACTIVE, so a coincident strobe is kept.
        if (state_q == ACTIVE && ioctl_wr) begin
            if (buf_valid_q) err_overrun_d = 1'b1;
            else begin
                buf_valid_d = 1'b1;
                buf_addr_d  = ioctl_addr;
                buf_data_d  = ioctl_dout;
            end
        end
        if (mem_req_q) begin
            if (mem_ack) begin
                mem_req_d    = 1'b0;
                buf_valid_d  = 1'b0;
                byte_count_d = byte_count_q + 25'd1;
            end
        end else if (buf_valid_q) begin
            if (!bin_q) begin
                mem_req_d   = rom_ok;
                mem_sel_d   = 1'b0;
                mem_addr_d  = buf_addr_q[15:0] & ROM_MASK;
                mem_data_d  = buf_data_q;
                buf_valid_d = rom_ok;
                err_size_d  = err_size_q | !rom_ok;
            end else if (hdr_byte) begin
                buf_valid_d                = 1'b0;
                hdr_d[buf_addr_q[1:0]]     = 1'b1;
                load_addr_d = buf_addr_q[1:0] == 2'd0 ? {load_addr_q[15:8], buf_data_q} :
                              buf_addr_q[1:0] == 2'd1 ? {buf_data_q, load_addr_q[7:0]} : load_addr_q;
                exec_addr_d = buf_addr_q[1:0] == 2'd2 ? {exec_addr_q[15:8], buf_data_q} :
                              buf_addr_q[1:0] == 2'd3 ? {buf_data_q, exec_addr_q[7:0]} : exec_addr_q;
            end else begin
                mem_req_d  = 1'b1;
                mem_sel_d  = 1'b1;
                mem_addr_d = ram_addr;
                mem_data_d = buf_data_q;
            end
        end
    end

    assign wait_d = buf_valid_d | mem_req_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            dl_q          <= 1'b0;
            bin_q         <= 1'b0;
            buf_valid_q   <= 1'b0;
            buf_addr_q    <= '0;
            buf_data_q    <= '0;
            mem_req_q     <= 1'b0;
            mem_sel_q     <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_q    <= '0;
            load_addr_q   <= '0;
            exec_addr_q   <= '0;
            hdr_q         <= '0;
            exec_valid_q  <= 1'b0;
            cpu_hold_q    <= 1'b0;
            load_done_q   <= 1'b0;
            wait_q        <= 1'b0;
            byte_count_q  <= '0;
            err_size_q    <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dl_q          <= ioctl_download;
            bin_q         <= bin_d;
            buf_valid_q   <= buf_valid_d;
            buf_addr_q    <= buf_addr_d;
            buf_data_q    <= buf_data_d;
            mem_req_q     <= mem_req_d;
            mem_sel_q     <= mem_sel_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_q    <= mem_data_d;
            load_addr_q   <= load_addr_d;
            exec_addr_q   <= exec_addr_d;
            hdr_q         <= hdr_d;
            exec_valid_q  <= exec_valid_d;
            cpu_hold_q    <= cpu_hold_d;
            load_done_q   <= load_done_d;
            wait_q        <= wait_d;
            byte_count_q  <= byte_count_d;
            err_size_q    <= err_size_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    assign ioctl_wait  = wait_q;
    assign mem_req     = mem_req_q;
    assign mem_sel     = mem_sel_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data    = mem_data_q;
    assign cpu_hold    = cpu_hold_q;
    assign load_done   = load_done_q;
    assign exec_addr   = exec_addr_q;
    assign exec_valid  = exec_valid_q;
    assign byte_count  = byte_count_q;
    assign err_size    = err_size_q;
    assign err_overrun = err_overrun_q;
endmodule

// File: tb/tb_smc777_ioctl_loader.sv
// tb_smc777_ioctl_loader: directed stimulus with a write scoreboard; a negedge monitor pops expected
// memory writes on each new mem_req and checks handshake stability.
module tb_smc777_ioctl_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_download, ioctl_wr, ioctl_wait;
    logic [7:0]  ioctl_index, ioctl_dout;
    logic [24:0] ioctl_addr;
    logic        mem_req, mem_sel, mem_ack;
    logic [15:0] mem_addr, exec_addr;
    logic [7:0]  mem_data;
    logic        cpu_hold, load_done, exec_valid, err_size, err_overrun;
    logic [24:0] byte_count;

    typedef struct packed {logic sel; logic [15:0] addr; logic [7:0] data;} wr_t;
    wr_t  exp_q[$];
    int   n_chk = 0, n_fail = 0, done_cnt = 0;
    logic ack_tie = 1'b1;

    smc777_ioctl_loader dut (
        .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
        .mem_req(mem_req), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
        .cpu_hold(cpu_hold), .load_done(load_done), .exec_addr(exec_addr), .exec_valid(exec_valid),
        .byte_count(byte_count), .err_size(err_size), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Arbiter model: either always acknowledges or acknowledges 5 cycles into each request.
    initial begin : arbiter
        int cnt;
        cnt = 0;
        mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_tie) mem_ack = 1'b1;
            else if (mem_req) begin
                cnt++;
                mem_ack = cnt >= 5;
            end else begin
                cnt = 0;
                mem_ack = 1'b0;
            end
        end
    end

    initial begin : monitor
        logic prev;
        wr_t  cur, e;
        prev = 1'b0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (load_done) done_cnt++;
            if (mem_req) begin
                chk("wait_during_req", ioctl_wait, 1);
                if (!prev) begin
                    cur = {mem_sel, mem_addr, mem_data};
                    chk("write_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("wr_sel", mem_sel, e.sel);
                        chk("wr_addr", mem_addr, e.addr);
                        chk("wr_data", mem_data, e.data);
                    end
                end else chk("req_stable", {mem_sel, mem_addr, mem_data}, cur);
            end
            prev = mem_req;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (ioctl_wait && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_bound", n < 100, 1);
    endtask

    task automatic start(input logic [7:0] idx);
        ioctl_index = idx;
        ioctl_download = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr = 1'b1;
        @(posedge clk); #1;
        ioctl_wr = 1'b0;
        wait_idle();
    endtask

    task automatic end_dl();
        int n = 0;
        ioctl_download = 1'b0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!load_done && n < 50);
        chk("load_done_seen", load_done, 1);
        chk("cpu_hold_in_done", cpu_hold, 1);
        @(posedge clk); #1;
        chk("load_done_pulse", load_done, 0);
        chk("cpu_hold_released", cpu_hold, 0);
    endtask

    initial begin
        int d;
        reset = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index = '0;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_wait", ioctl_wait, 0);
        chk("rst_cpu_hold", cpu_hold, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_exec_valid", exec_valid, 0);
        chk("rst_byte_count", byte_count, 0);
        chk("rst_errs", {err_size, err_overrun}, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // BIOS with immediate ack
        d = done_cnt;
        start(8'd0);
        chk("bios_cpu_hold", cpu_hold, 1);
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back({1'b0, 16'(i), 8'(i)});
            send(25'(i), 8'(i));
        end
        chk("bios_hold_before_end", cpu_hold, 1);
        end_dl();
        chk("bios_byte_count", byte_count, 256);
        chk("bios_done_once", done_cnt - d, 1);
        chk("bios_errs", {err_size, err_overrun}, 0);
        chk("bios_drained", exp_q.size(), 0);

        // Slow arbiter
        ack_tie = 1'b0;
        start(8'd0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({1'b0, 16'(16 + i), 8'(8'h5A + i)});
            send(25'(16 + i), 8'(8'h5A + i));
        end
        end_dl();
        chk("slow_byte_count", byte_count, 4);
        chk("slow_overrun", err_overrun, 0);
        chk("slow_drained", exp_q.size(), 0);
        ack_tie = 1'b1;

        // BIN header and RAM wrap
        start(8'd1);
        send(25'd0, 8'hFE);
        send(25'd1, 8'hFF);
        send(25'd2, 8'h00);
        send(25'd3, 8'h80);
        exp_q.push_back({1'b1, 16'hFFFE, 8'hAA});
        send(25'd4, 8'hAA);
        exp_q.push_back({1'b1, 16'hFFFF, 8'hBB});
        send(25'd5, 8'hBB);
        exp_q.push_back({1'b1, 16'h0000, 8'hCC});
        send(25'd6, 8'hCC);
        end_dl();
        chk("bin_exec_addr", exec_addr, 16'h8000);
        chk("bin_exec_valid", exec_valid, 1);
        chk("bin_byte_count", byte_count, 3);
        chk("bin_err_size", err_size, 0);
        chk("bin_drained", exp_q.size(), 0);

        // ROM overflow
        start(8'd0);
        send(25'h4000, 8'h77);
        end_dl();
        chk("rom_ovf_err_size", err_size, 1);
        chk("rom_ovf_byte_count", byte_count, 0);

        // Short BIN
        start(8'd1);
        send(25'd0, 8'h00);
        send(25'd1, 8'h10);
        end_dl();
        chk("short_err_size", err_size, 1);
        chk("short_exec_valid", exec_valid, 0);
        chk("short_byte_count", byte_count, 0);

        // Overrun: second strobe while the buffer is still full
        ack_tie = 1'b0;
        start(8'd0);
        exp_q.push_back({1'b0, 16'h0000, 8'h11});
        ioctl_addr = 25'd0;
        ioctl_dout = 8'h11;
        ioctl_wr = 1'b1;
        @(posedge clk); #1;
        ioctl_addr = 25'd1;
        ioctl_dout = 8'h22;
        @(posedge clk); #1;
        ioctl_wr = 1'b0;
        chk("ovr_flag_early", err_overrun, 1);
        wait_idle();
        end_dl();
        chk("ovr_flag", err_overrun, 1);
        chk("ovr_byte_count", byte_count, 1);
        chk("ovr_drained", exp_q.size(), 0);

        // Reset while mem_req is high
        start(8'd0);
        exp_q.push_back({1'b0, 16'h0005, 8'h99});
        ioctl_addr = 25'd5;
        ioctl_dout = 8'h99;
        ioctl_wr = 1'b1;
        @(posedge clk); #1;
        ioctl_wr = 1'b0;
        begin
            int n = 0;
            while (!mem_req && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            chk("rstmid_req_seen", mem_req, 1);
        end
        d = done_cnt;
        reset = 1'b1;
        #1;
        chk("rstmid_mem_req", mem_req, 0);
        chk("rstmid_cpu_hold", cpu_hold, 0);
        chk("rstmid_wait", ioctl_wait, 0);
        exp_q.delete();
        ioctl_download = 1'b0;
        ack_tie = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rstmid_no_done", done_cnt - d, 0);
        start(8'd0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({1'b0, 16'(100 + i), 8'(8'hC0 + i)});
            send(25'(100 + i), 8'(8'hC0 + i));
        end
        end_dl();
        chk("rstmid_after_count", byte_count, 3);
        chk("rstmid_after_drained", exp_q.size(), 0);

        // Ignored index
        d = done_cnt;
        start(8'd2);
        for (int i = 0; i < 10; i++) begin
            send(25'(i), 8'(i));
            chk("ign_wait", ioctl_wait, 0);
            chk("ign_cpu_hold", cpu_hold, 0);
            chk("ign_mem_req", mem_req, 0);
        end
        ioctl_download = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("ign_no_done", done_cnt - d, 0);
        chk("ign_byte_count", byte_count, 3);

        chk("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
